fd_frame_scheduler: RTL
=======================

FD_FRAME_SCHEDULER -- requirements
Module: fd_frame_scheduler

Interface
REQ-001 SHALL have parameters: DW, default 16, bin data width; AW, default 11, bin address width (NFREQ = 2**AW bins per frame); MIN_GAP, default 4, idle cycles required between output bursts.
REQ-002 SHALL have ports:
- clk_i  input  1  sole clock; all logic on rising edge.
- srst_n_i  input  1  synchronous reset, active-low.
- bin_valid_i  input  1  upstream bin strobe; gaps between strobes allowed.
- bin_first_i  input  1  marks bin 0 of a frame; qualified by bin_valid_i.
- bin_data_i  input  DW  real part of the bin.
- enable_i  input  1  permits new output bursts.
- sob_o  output  1  start-of-burst pulse, aligned with bin 0 on freq_o.
- eob_o  output  1  end-of-burst pulse, aligned with bin NFREQ-1.
- freq_o  output  DW  contiguous bin stream to the frequency-domain processor.
- busy_o  output  1  high while a burst is in progress.
- overflow_o  output  1  sticky; a frame was dropped because both banks were full.
- resync_o  output  1  one-cycle pulse; a partial frame was discarded.
- frame_cnt_o  output  16  count of bursts emitted, wrapping.

Function
REQ-003 SHALL buffer frames in two banks of NFREQ x DW simple dual-port RAM (ping-pong), each with a full flag.
REQ-004 Write FSM SHALL have states W_IDLE and W_FILL.
- W_IDLE: ignores bins without bin_first_i.
- valid & first: writes bin to address 0 of the current write bank, sets wr_addr=1, goes to W_FILL.
REQ-005 In W_FILL, each valid bin SHALL be written at wr_addr, then wr_addr increments.
- Write at address NFREQ-1: sets the bank full flag, toggles the write bank, returns to W_IDLE.
REQ-006 If valid & first arrives in W_FILL with wr_addr != 0, SHALL:
- discard the partial frame;
- write that bin to address 0 of the same bank and set wr_addr=1;
- pulse resync_o for one cycle.
REQ-007 If the target write bank is full when a frame's bin 0 arrives, SHALL:
- drop the entire frame (no writes until the next bin_first_i);
- set overflow_o; it stays high until reset.
REQ-008 Read FSM SHALL have states R_IDLE, R_BURST and R_GAP.
- R_IDLE -> R_BURST when the read bank is full and enable_i=1.
- R_BURST: reads addresses 0..NFREQ-1 on consecutive cycles with no stalls.
- After address NFREQ-1 is read: clears that bank's full flag, toggles the read bank, enters R_GAP.
- R_GAP: lasts exactly MIN_GAP cycles, then returns to R_IDLE.
REQ-009 RAM read latency is 1 cycle.
- freq_o, sob_o and eob_o SHALL be registered so that sob_o is high exactly in the cycle freq_o carries bin 0.
- eob_o SHALL be high exactly in the cycle freq_o carries bin NFREQ-1.
- Each burst SHALL therefore be NFREQ output cycles, first output one cycle after the R_IDLE->R_BURST transition.
REQ-010 freq_o SHALL be 0 outside bursts. busy_o SHALL be high from the R_BURST entry cycle through the eob_o cycle.
REQ-011 enable_i deasserted mid-burst SHALL NOT truncate the burst; it only blocks the next R_IDLE->R_BURST transition.
REQ-012 If the read side clears a full flag in the same cycle the write side checks it, the write side SHALL see the bank as free (clear has priority).
REQ-013 Bank full-flag set (write) and clear (read) of different banks in the same cycle SHALL both take effect.
REQ-014 frame_cnt_o SHALL increment by 1 in the eob_o cycle and wrap from 16'hFFFF to 0.
REQ-015 A write and a read to the same bank in the same cycle SHALL be impossible by construction (full flag gating).

Reset
REQ-016 srst_n_i=0 at a clock edge SHALL, mid-operation included:
- abort any fill or burst;
- set both FSMs to idle, both banks empty, both bank pointers to bank 0;
- zero all outputs: sob_o, eob_o, freq_o, busy_o, overflow_o, resync_o, frame_cnt_o.
REQ-017 RAM contents SHALL NOT need clearing on reset.

Verification
REQ-018 Fill one frame with bin k = k+1 at one strobe every 3 cycles, enable_i=1 -> single burst; sob_o with freq_o=1; eob_o with freq_o=2048 exactly 2047 cycles later; frame_cnt_o=1.
REQ-019 enable_i=0, send 3 frames back-to-back -> overflow_o=1 after the third frame's bin 0, no bursts; set enable_i=1 -> exactly 2 bursts (frames 1 and 2), separated by >= MIN_GAP idle cycles.
REQ-020 Send 100 bins of a frame, then bin_first_i with data 0xAAAA -> resync_o pulses once; the subsequent complete frame bursts with bin 0 = 0xAAAA.
REQ-021 Drop enable_i at burst cycle 10 -> burst completes all 2048 cycles; the next full bank is not read until enable_i returns high.
REQ-022 Assert srst_n_i=0 for one cycle at burst cycle 500 -> next cycle all outputs are 0 and busy_o=0; a fresh frame afterward produces a normal burst with frame_cnt_o=1.

Source files
------------

// File: rtl/fd_frame_scheduler.sv
// Ping-pong frame buffer: gathers a gappy upstream bin stream into two banks and
// replays each complete frame as one contiguous NFREQ-cycle burst with idle gaps between bursts.
module fd_frame_scheduler #(
   parameter int DW      = 16,
   parameter int AW      = 11,
   parameter int MIN_GAP = 4
) (
   input  logic          clk_i,
   input  logic          srst_n_i,
   input  logic          bin_valid_i,
   input  logic          bin_first_i,
   input  logic [DW-1:0] bin_data_i,
   input  logic          enable_i,
   output logic          sob_o,
   output logic          eob_o,
   output logic [DW-1:0] freq_o,
   output logic          busy_o,
   output logic          overflow_o,
   output logic          resync_o,
   output logic [15:0]   frame_cnt_o
);
   localparam int NFREQ = 2**AW;
   localparam int GW    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(NFREQ - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(MIN_GAP - 1);

   typedef enum logic       {W_IDLE, W_FILL} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_BURST, R_GAP} rstate_t;

   logic [DW-1:0] mem [2*NFREQ];

   wstate_t       wstate_q, wstate_d;
   logic          wr_bank_q, wr_bank_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [AW-1:0] waddr;
   logic          we, wr_set, bank_free;
   logic          overflow_q, overflow_d;
   logic          resync_q, resync_d;

   rstate_t       rstate_q, rstate_d;
   logic          rd_bank_q, rd_bank_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          rd_en, rd_clr;

   logic [1:0]    full_q, full_d;
   logic [DW-1:0] rdata_q;
   logic          vld_q, sob_q, eob_q;
   logic [15:0]   frame_cnt_q;

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         wstate_q    <= W_IDLE;
         wr_bank_q   <= 1'b0;
         wr_addr_q   <= '0;
         overflow_q  <= 1'b0;
         resync_q    <= 1'b0;
         rstate_q    <= R_IDLE;
         rd_bank_q   <= 1'b0;
         rd_addr_q   <= '0;
         gap_q       <= '0;
         full_q      <= 2'b00;
         vld_q       <= 1'b0;
         sob_q       <= 1'b0;
         eob_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         wstate_q    <= wstate_d;
         wr_bank_q   <= wr_bank_d;
         wr_addr_q   <= wr_addr_d;
         overflow_q  <= overflow_d;
         resync_q    <= resync_d;
         rstate_q    <= rstate_d;
         rd_bank_q   <= rd_bank_d;
         rd_addr_q   <= rd_addr_d;
         gap_q       <= gap_d;
         full_q      <= full_d;
         vld_q       <= rd_en;
         sob_q       <= rd_en && (rd_addr_q == '0);
         eob_q       <= rd_en && (rd_addr_q == LAST_ADDR);
         if (rd_en && (rd_addr_q == LAST_ADDR))
            frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   // RAM contents are never reset; the 1-cycle read data is masked by vld_q
   always_ff @(posedge clk_i) begin
      if (we)
         mem[{wr_bank_q, waddr}] <= bin_data_i;
      if (rd_en)
         rdata_q <= mem[{rd_bank_q, rd_addr_q}];
   end

   // A bank being released by the reader this cycle already counts as free
   assign bank_free = !full_q[wr_bank_q] || (rd_clr && (rd_bank_q == wr_bank_q));

   always_comb begin
      wstate_d   = wstate_q;
      wr_bank_d  = wr_bank_q;
      wr_addr_d  = wr_addr_q;
      waddr      = '0;
      we         = 1'b0;
      wr_set     = 1'b0;
      resync_d   = 1'b0;
      overflow_d = overflow_q;
      unique case (wstate_q)
         W_IDLE: begin
            if (bin_valid_i && bin_first_i) begin
               if (bank_free) begin
                  we        = 1'b1;
                  wr_addr_d = AW'(1);
                  wstate_d  = W_FILL;
               end else begin
                  overflow_d = 1'b1;
               end
            end
         end
         W_FILL: begin
            if (bin_valid_i && bin_first_i) begin
               we        = 1'b1;
               wr_addr_d = AW'(1);
               resync_d  = 1'b1;
            end else if (bin_valid_i) begin
               we        = 1'b1;
               waddr     = wr_addr_q;
               wr_addr_d = wr_addr_q + AW'(1);
               if (wr_addr_q == LAST_ADDR) begin
                  wr_set    = 1'b1;
                  wr_bank_d = ~wr_bank_q;
                  wstate_d  = W_IDLE;
               end
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   always_comb begin
      rstate_d  = rstate_q;
      rd_bank_d = rd_bank_q;
      rd_addr_d = rd_addr_q;
      gap_d     = gap_q;
      rd_en     = 1'b0;
      rd_clr    = 1'b0;
      unique case (rstate_q)
         R_IDLE: begin
            if (full_q[rd_bank_q] && enable_i) begin
               rstate_d  = R_BURST;
               rd_addr_d = '0;
            end
         end
         R_BURST: begin
            rd_en     = 1'b1;
            rd_addr_d = rd_addr_q + AW'(1);
            if (rd_addr_q == LAST_ADDR) begin
               rd_clr    = 1'b1;
               rd_bank_d = ~rd_bank_q;
               gap_d     = '0;
               rstate_d  = R_GAP;
            end
         end
         R_GAP: begin
            gap_d = gap_q + GW'(1);
            if (gap_q == GAP_LAST)
               rstate_d = R_IDLE;
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      full_d = full_q;
      if (rd_clr)
         full_d[rd_bank_q] = 1'b0;
      if (wr_set)
         full_d[wr_bank_q] = 1'b1;
   end

   always_comb begin
      freq_o      = vld_q ? rdata_q : '0;
      sob_o       = sob_q;
      eob_o       = eob_q;
      busy_o      = (rstate_q == R_BURST) || eob_q;
      overflow_o  = overflow_q;
      resync_o    = resync_q;
      frame_cnt_o = frame_cnt_q;
   end
endmodule
